dec_busy_vec: RTL
=================

// Module: dec_busy_vec
//
// PURPOSE
//   Index-to-one-hot decoder with state: inverse of the priority encoder (pe).
//   Takes encoded set/clear requests (e.g. an allocated RS/ROB slot index and a
//   freed slot index) and keeps a registered one-hot busy vector.
//   Also keeps an occupancy count and full/empty flags, and reports misuse.
//   Its busy vector feeds back, inverted, into pe as the free-slot request.
//
// PARAMETERS
//   IDX_WIDTH  4              width of set_idx/clr_idx
//   DEPTH      1<<IDX_WIDTH   number of tracked entries; DEPTH <= 2**IDX_WIDTH
//
// PORTS
//   clock       in   1            rising-edge clock
//   reset_n     in   1            asynchronous, active-low reset
//   set_valid   in   1            request to mark entry set_idx busy
//   set_idx     in   IDX_WIDTH    encoded entry to set
//   clr_valid   in   1            request to mark entry clr_idx free
//   clr_idx     in   IDX_WIDTH    encoded entry to clear
//   busy        out  DEPTH        registered busy vector; bit i = entry i busy
//   dec_onehot  out  DEPTH        registered one-hot of last accepted set_idx (0 if none)
//   busy_cnt    out  IDX_WIDTH+1  number of busy entries, 0..DEPTH
//   full        out  1            busy_cnt == DEPTH (decoded from registers)
//   empty       out  1            busy_cnt == 0 (decoded from registers)
//   set_err     out  1            registered 1-cycle pulse: set request rejected
//   clr_err     out  1            registered 1-cycle pulse: clear request rejected
//
// BEHAVIOUR
//   - Reset (reset_n=0, async, no clock needed):
//     busy=0, dec_onehot=0, busy_cnt=0, set_err=0, clr_err=0, so empty=1, full=0.
//     If reset is asserted mid-operation, the reset values take effect at once
//     and any request pending in that cycle is dropped.
//   - All state updates on the rising edge of clock. Latency is 1 cycle: a request
//     at edge N is visible on busy/busy_cnt/dec_onehot/err just after edge N.
//   - Each cycle, the clear is evaluated first, then the set, against the
//     post-clear vector:
//       clr_ok = clr_valid & (clr_idx < DEPTH) & busy[clr_idx]
//       mid    = busy & ~(clr_ok << clr_idx)
//       set_ok = set_valid & (set_idx < DEPTH) & ~mid[set_idx]
//       busy'  = mid | (set_ok << set_idx)
//       busy_cnt' = busy_cnt - clr_ok + set_ok   (never wraps; 0..DEPTH by construction)
//   - clr_err' = clr_valid & ~clr_ok   (entry already free, or idx >= DEPTH). No state change.
//   - set_err' = set_valid & ~set_ok   (entry busy after clear, or idx >= DEPTH). No state change.
//   - dec_onehot' = set_ok ? (1 << set_idx) : 0. Exactly one bit or no bits set.
//   - Same index set and cleared in one cycle with the entry busy: clear, then set.
//     Result: busy stays 1, count unchanged, no errors, dec_onehot has that bit.
//   - Same index set and cleared in one cycle with the entry free: clr_err=1,
//     set accepted, count +1.
//   - Full: a set to any other index gives set_err. A set paired with a valid
//     clear of the same index is accepted.
//   - Empty: any clear gives clr_err; busy_cnt stays 0 (no underflow).
//   - A cycle with no valid request: busy and busy_cnt hold, dec_onehot=0,
//     err=0.
//
// TESTING
//   1 reset: assert reset_n=0 mid-run with busy=16'h00F0 -> busy=0, cnt=0,
//     empty=1 immediately, before the next clock.
//   2 set idx 4,8,15 on consecutive cycles -> busy=16'h8110, cnt=3,
//     dec_onehot=16'h0010 / 16'h0100 / 16'h8000 in turn.
//   3 set idx 8 again when busy -> set_err=1 for 1 cycle, busy unchanged; clear
//     idx 3 when free -> clr_err=1, cnt unchanged.
//   4 same-cycle clr 8 + set 8 (busy) -> busy[8]=1, cnt same, no errors;
//     same-cycle clr 2 + set 5 -> clr_err=1, busy[5]=1, cnt+1.
//   5 fill all 16 -> full=1, cnt=16; set 0 -> set_err=1; clr 0 + set 0 ->
//     accepted, full=1; clear all -> empty=1, then clr 0 -> clr_err=1, cnt=0.
//   6 DEPTH=12 instance: set idx 13 -> set_err=1, busy unchanged;
//     closed loop with pe on ~busy allocates 0..11 in order.

Source files
------------

// File: rtl/dec_busy_vec.sv
// Index-to-one-hot busy tracker: registered busy vector, occupancy count,
// full/empty flags and one-cycle misuse pulses for set/clear requests.
module dec_busy_vec #(
  parameter int IDX_WIDTH = 4,
  parameter int DEPTH     = 1 << IDX_WIDTH
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 set_valid,
  input  logic [IDX_WIDTH-1:0] set_idx,
  input  logic                 clr_valid,
  input  logic [IDX_WIDTH-1:0] clr_idx,
  output logic [DEPTH-1:0]     busy,
  output logic [DEPTH-1:0]     dec_onehot,
  output logic [IDX_WIDTH:0]   busy_cnt,
  output logic                 full,
  output logic                 empty,
  output logic                 set_err,
  output logic                 clr_err
);

  localparam logic [IDX_WIDTH:0] DEPTH_W =
    (IDX_WIDTH + 1)'(DEPTH);

  logic [DEPTH-1:0]   busy_q;
  logic [DEPTH-1:0]   dec_q;
  logic [DEPTH-1:0]   set_hot;
  logic [DEPTH-1:0]   clr_hot;
  logic [DEPTH-1:0]   mid;
  logic [DEPTH-1:0]   busy_d;
  logic [IDX_WIDTH:0] cnt_q;
  logic [IDX_WIDTH:0] cnt_d;
  logic               set_ok;
  logic               clr_ok;
  logic               set_err_q;
  logic               clr_err_q;

  // Out-of-range indices decode to all-zero, which rejects them below.
  always_comb begin
    set_hot = '0;
    clr_hot = '0;
    for (int i = 0; i < DEPTH; i++) begin
      set_hot[i] = (set_idx == IDX_WIDTH'(i));
      clr_hot[i] = (clr_idx == IDX_WIDTH'(i));
    end
  end

  assign clr_ok = clr_valid & (|(clr_hot & busy_q));
  assign mid    = clr_ok ? (busy_q & ~clr_hot) : busy_q;

  // Set is judged against the post-clear vector.
  assign set_ok = set_valid & (|set_hot)
                & ~(|(set_hot & mid));
  assign busy_d = set_ok ? (mid | set_hot) : mid;

  assign cnt_d = cnt_q
               - {{IDX_WIDTH{1'b0}}, clr_ok}
               + {{IDX_WIDTH{1'b0}}, set_ok};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy_q    <= '0;
      dec_q     <= '0;
      cnt_q     <= '0;
      set_err_q <= 1'b0;
      clr_err_q <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      dec_q     <= set_ok ? set_hot : '0;
      cnt_q     <= cnt_d;
      set_err_q <= set_valid & ~set_ok;
      clr_err_q <= clr_valid & ~clr_ok;
    end
  end

  assign busy       = busy_q;
  assign dec_onehot = dec_q;
  assign busy_cnt   = cnt_q;
  assign full       = (cnt_q == DEPTH_W);
  assign empty      = (cnt_q == '0);
  assign set_err    = set_err_q;
  assign clr_err    = clr_err_q;

endmodule
